// File: rtl/intercal_alu_port.sv
// intercal_alu_port: byte-serial host port and sequencer for the INTERCAL ALU.
// Operands shift in a byte per wr strobe; the result is read back a byte per rd strobe.
module intercal_alu_port (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_MINGLE = 3'd0;
   localparam logic [2:0] OP_SELECT = 3'd1;

   function automatic logic [31:0] mingle_f(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] r;
      r = 32'd0;
      for (int j = 0; j < 16; j++) begin
         r[2*j+1] = a[j];
         r[2*j]   = b[j];
      end
      return r;
   endfunction

   function automatic logic [31:0] unary_f(input logic [2:0] op, input logic [31:0] a);
      logic [15:0] h;
      logic [15:0] hr;
      logic [31:0] ar;
      logic [31:0] r;
      h  = a[15:0];
      hr = {h[0], h[15:1]};
      ar = {a[0], a[31:1]};
      case (op)
         3'd2:    r = {16'd0, h & hr};
         3'd3:    r = {16'd0, h | hr};
         3'd4:    r = {16'd0, h ^ hr};
         3'd5:    r = a & ar;
         3'd6:    r = a | ar;
         3'd7:    r = a ^ ar;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] byte_f(input logic [31:0] r, input logic [1:0] p);
      logic [7:0] b;
      case (p)
         2'd0:    b = r[31:24];
         2'd1:    b = r[23:16];
         2'd2:    b = r[15:8];
         2'd3:    b = r[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [63:0] ab_q, ab_d;
   logic [31:0] r_q, r_d;
   logic [4:0]  i_q, i_d;
   logic [4:0]  k_q, k_d;
   logic [1:0]  p_q, p_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  uo_q, uo_d;
   logic [7:0]  uio_q, uio_d;

   logic        wr_s, go_s, rd_s;
   logic [31:0] a_s, b_s;
   logic        unused_s;

   assign wr_s     = ena & uio_in[0];
   assign go_s     = ena & uio_in[1];
   assign rd_s     = ena & uio_in[5];
   assign a_s      = ab_q[63:32];
   assign b_s      = ab_q[31:0];
   assign unused_s = ^uio_in[7:6];

   // Next-state logic: strobe decode, sequencing and the ALU itself.
   always_comb begin
      state_d = state_q;
      ab_d    = ab_q;
      r_d     = r_q;
      i_d     = i_q;
      k_d     = k_q;
      p_d     = p_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go_s) begin
               op_d    = uio_in[4:2];
               r_d     = 32'd0;
               i_d     = 5'd0;
               k_d     = 5'd0;
               p_d     = 2'd0;
               state_d = ST_RUN;
            end else begin
               if (wr_s) begin
                  ab_d = {ab_q[55:0], ui_in};
               end else begin
                  ab_d = ab_q;
               end
               if (rd_s && (state_q == ST_DONE)) begin
                  p_d = p_q + 2'd1;
               end else begin
                  p_d = p_q;
               end
            end
         end
         ST_RUN: begin
            if (!ena) begin
               state_d = state_q;
            end else if (op_q == OP_SELECT) begin
               // One operand bit per cycle; selected bits pack upward from R[0].
               if (b_s[i_q]) begin
                  r_d[k_q] = a_s[i_q];
                  k_d      = k_q + 5'd1;
               end else begin
                  k_d = k_q;
               end
               i_d = i_q + 5'd1;
               if (i_q == 5'd31) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (op_q == OP_MINGLE) begin
               r_d     = mingle_f(a_s[15:0], b_s[15:0]);
               state_d = ST_DONE;
            end else begin
               r_d     = unary_f(op_q, a_s);
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from next state so byte 0 appears with done.
      if (state_d == ST_DONE) begin
         uo_d = byte_f(r_d, p_d);
      end else begin
         uo_d = 8'h00;
      end
      uio_d = {(state_d == ST_DONE), (state_d == ST_RUN), 6'd0};
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ab_q    <= 64'd0;
         r_q     <= 32'd0;
         i_q     <= 5'd0;
         k_q     <= 5'd0;
         p_q     <= 2'd0;
         op_q    <= 3'd0;
         uo_q    <= 8'h00;
         uio_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         ab_q    <= ab_d;
         r_q     <= r_d;
         i_q     <= i_d;
         k_q     <= k_d;
         p_q     <= p_d;
         op_q    <= op_d;
         uo_q    <= uo_d;
         uio_q   <= uio_d;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = uio_q;
   assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_intercal_alu_port.sv
// Scoreboard bench for intercal_alu_port: expectations queued at go, checked at readback.
module tb_intercal_alu_port;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   intercal_alu_port dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Independent reference: bit loops straight from the operation definitions.
   function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int k;
      r = 32'd0;
      k = 0;
      case (op)
         3'd0: for (int j = 0; j < 16; j++) begin r[2*j+1] = a[j]; r[2*j] = b[j]; end
         3'd1: for (int j = 0; j < 32; j++) if (b[j]) begin r[k] = a[j]; k++; end
         3'd2, 3'd3, 3'd4:
            for (int j = 0; j < 16; j++) begin
               logic x, y;
               x = a[j];
               y = a[(j + 1) % 16];
               r[j] = (op == 3'd2) ? (x & y) : (op == 3'd3) ? (x | y) : (x ^ y);
            end
         default:
            for (int j = 0; j < 32; j++) begin
               logic x, y;
               x = a[j];
               y = a[(j + 1) % 32];
               r[j] = (op == 3'd5) ? (x & y) : (op == 3'd6) ? (x | y) : (x ^ y);
            end
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] v;
      v = {a, b};
      for (int n = 0; n < 8; n++) begin
         ui_in  = v[63:56];
         v      = v << 8;
         uio_in = 8'h01;
         tick();
      end
      uio_in = 8'h00;
      ui_in  = 8'h00;
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] exp);
      exp_q.push_back(exp);
      uio_in = {3'b000, op, 2'b10};
      tick();
      uio_in = 8'h00;
   endtask

   task automatic finish_op(input string tag, input int exp_cyc);
      int cnt;
      logic [31:0] r;
      logic [31:0] e;
      cnt = 0;
      while (uio_out[6] && cnt < 200) begin
         cnt++;
         tick();
      end
      check_val({tag, "_busy_cycles"}, cnt, exp_cyc);
      check_val({tag, "_done"}, {24'd0, uio_out}, 32'h0000_0080);
      r = 32'd0;
      for (int n = 0; n < 4; n++) begin
         r      = {r[23:0], uo_out};
         uio_in = 8'h20;
         tick();
         uio_in = 8'h00;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check_val({tag, "_result"}, r, e);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      check_val("rst_uo_out", {24'd0, uo_out}, 32'h0);
      check_val("rst_uio_out", {24'd0, uio_out}, 32'h0);
      check_val("rst_uio_oe", {24'd0, uio_oe}, 32'hC0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Mingle, then a 5th read wraps to byte 0
      load(32'h0000_FFFF, 32'h0000_0000);
      start_op(3'd0, 32'hAAAA_AAAA);
      finish_op("mingle", 1);
      check_val("mingle_wrap", {24'd0, uo_out}, 32'hAA);

      load(32'hFFFF_FFFF, 32'h0000_F0F0);
      start_op(3'd1, 32'h0000_00FF);
      finish_op("sel_f0f0", 32);
      load(32'hAAAA_AAAA, 32'hFFFF_0000);
      start_op(3'd1, 32'h0000_AAAA);
      finish_op("sel_aaaa", 32);
      load(32'h1234_5678, 32'h0000_0000);
      start_op(3'd1, 32'h0000_0000);
      finish_op("sel_zero", 32);

      load(32'h0000_000F, 32'h0);
      start_op(3'd4, 32'h0000_8008);
      finish_op("xor16", 1);
      load(32'hFFFF_FFFF, 32'h0);
      start_op(3'd5, 32'hFFFF_FFFF);
      finish_op("and32", 1);
      load(32'h0000_0001, 32'h0);
      start_op(3'd6, 32'h8000_0001);
      finish_op("or32", 1);
      check_val("or32_wrap", {24'd0, uo_out}, 32'h80);

      // A few randomised operands across all opcodes
      for (int n = 0; n < 8; n++) begin
         ra = $urandom;
         rb = $urandom;
         load(ra, rb);
         start_op(n[2:0], ref_f(n[2:0], ra, rb));
         finish_op($sformatf("rand_op%0d", n), (n == 1) ? 32 : 1);
      end

      // go/wr during a select are ignored; operands verified by a follow-up mingle
      load(32'hFFFF_FFFF, 32'h0000_F0F0);
      start_op(3'd1, 32'h0000_00FF);
      tick(); tick(); tick();
      ui_in  = 8'h55;
      uio_in = {3'b000, 3'd5, 2'b11};
      tick();
      uio_in = 8'h01;
      tick();
      uio_in = 8'h00;
      ui_in  = 8'h00;
      finish_op("ign_sel", 27);
      start_op(3'd0, ref_f(3'd0, 32'hFFFF_FFFF, 32'h0000_F0F0));
      finish_op("ign_opnd", 1);

      // go+wr in the same cycle: the byte is dropped
      load(32'h0000_1234, 32'h0000_5678);
      exp_q.push_back(ref_f(3'd0, 32'h0000_1234, 32'h0000_5678));
      ui_in  = 8'h77;
      uio_in = 8'h03;
      tick();
      uio_in = 8'h00;
      ui_in  = 8'h00;
      finish_op("gowr", 1);

      // Reset at RUN cycle 10 aborts the select
      load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      start_op(3'd1, 32'hFFFF_FFFF);
      for (int n = 0; n < 9; n++) tick();
      check_val("pre_rst_busy", {24'd0, uio_out}, 32'h40);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_uo_out", {24'd0, uo_out}, 32'h0);
      check_val("mid_rst_uio_out", {24'd0, uio_out}, 32'h0);
      check_val("mid_rst_uio_oe", {24'd0, uio_oe}, 32'hC0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_op(3'd1, 32'h0000_0000);
      finish_op("post_rst_sel", 32);
      start_op(3'd7, 32'h0000_0000);
      finish_op("post_rst_xor32", 1);

      // ena low for 5 cycles stretches the select by 5
      load(32'hFFFF_FFFF, 32'h0000_F0F0);
      start_op(3'd1, 32'h0000_00FF);
      for (int n = 0; n < 5; n++) tick();
      ena = 1'b0;
      for (int n = 0; n < 5; n++) tick();
      ena = 1'b1;
      finish_op("ena_sel", 27);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
